// File: rtl/nandn_deglitch_if.sv
// nandn_deglitch_if: bundles the cell signals; master drives i/mode/en and sees o/chg/busy, slave is the cell
interface nandn_deglitch_if #(
  parameter int N = 2
);
  logic [N-1:0] i;
  logic [1:0] mode;
  logic en;
  logic o;
  logic chg;
  logic busy;
  modport master(output i, mode, en, input o, chg, busy);
  modport slave(input i, mode, en, output o, chg, busy);
endinterface

// File: rtl/nandn_deglitch.sv
// nandn_deglitch: N-input NAND/AND/NOR/OR cell with optional 2-flop sync and FILT-edge deglitch; ports clk, rst, CELV/CELG/SUB (power, no function), bus (slave: i, mode, en in; o, chg, busy out)
module nandn_deglitch #(
  parameter int N = 2,
  parameter int FILT = 4,
  parameter int SYNC = 2,
  parameter logic RST_VAL = 1'b1
) (
  input logic clk,
  input logic rst,
  input logic CELV,
  input logic CELG,
  input logic SUB,
  nandn_deglitch_if.slave bus
);
  localparam int CW = $clog2(FILT + 1);
  localparam logic [CW-1:0] LAST = CW'(FILT - 1);
  logic [N-1:0] in_s;
  logic unused_pwr;
  logic f, upd, o_q, o_d, chg_q, chg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign unused_pwr = CELV ^ CELG ^ SUB;
  generate
    if (SYNC == 2) begin : g_sync
      logic [N-1:0] s1_q, s2_q;
      always_ff @(posedge clk) begin
        s1_q <= rst ? '0 : bus.i;
        s2_q <= rst ? '0 : s1_q;
      end
      assign in_s = s2_q;
    end else begin : g_nosync
      assign in_s = bus.i;
    end
  endgenerate
  always_comb begin
    f = bus.mode[1] ? (bus.mode[0] ? |in_s : ~|in_s) : (bus.mode[0] ? &in_s : ~&in_s);
    upd = bus.en && (f != o_q) && (cnt_q == LAST);
    cnt_d = (!bus.en || (f == o_q) || upd) ? '0 : cnt_q + 1'b1;
    o_d = upd ? f : o_q;
    chg_d = upd;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      o_q <= RST_VAL;
      chg_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      o_q <= o_d;
      chg_q <= chg_d;
    end
  end
  assign bus.o = o_q;
  assign bus.chg = chg_q;
  assign bus.busy = |cnt_q;
endmodule

// File: doc/nandn_deglitch.md
# nandn_deglitch

Parametrised successor to the 5V two-input NAND brick: an N-input NAND/AND/NOR/OR logic cell with runtime function select, an optional input synchroniser and a digital deglitch filter. The output changes only after the new logic result has been stable for FILT consecutive clocks. It serves the stepdown soft-start and protection logic, where raw comparator and enable inputs must not glitch downstream state. Power pins are carried through unchanged for the brick generator.

## Interface
- N, 2, number of logic inputs (2..8)
- FILT, 4, consecutive stable clocks required before `o` changes (1..255)
- SYNC, 2, synchroniser stages on `i` (0 or 2)
- RST_VAL, 1, value of `o` in reset

- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- CELV  input  1  cell supply; no logic function
- CELG  input  1  cell ground; no logic function
- SUB  input  1  substrate; no logic function
- i  input  N  logic inputs, asynchronous when SYNC=2
- mode  input  2  function select: 00 NAND, 01 AND, 10 NOR, 11 OR
- en  input  1  filter enable
- o  output  1  filtered, registered result
- chg  output  1  one-cycle pulse on the edge where `o` toggles
- busy  output  1  filter counter non-zero (a change is pending)

## Operation
- Synchroniser: with SYNC=2, `i` passes through two flops per bit to give `is`. With SYNC=0, `is = i`.
- `f` is the combinational function of `is` selected by `mode`: NAND = ~&is, AND = &is, NOR = ~|is, OR = |is. A `mode` change is treated exactly like an input change.
- Counter `cnt` is ceil(log2(FILT+1)) bits wide. Per edge, with en=1:
  - f == o: cnt <= 0.
  - f != o and cnt < FILT-1: cnt <= cnt+1.
  - f != o and cnt == FILT-1: o <= f, chg <= 1, cnt <= 0.
- chg is 0 on every other edge.
- en=0: cnt <= 0, o holds, chg <= 0. The synchroniser keeps running.
- busy = (cnt != 0), combinational from `cnt`.
- Glitch rejection: if f returns to o before FILT consecutive mismatching edges, cnt clears and o does not move. A mismatch that ends exactly on the would-be update edge (f == o at that edge) produces no update.
- No saturation or wrap: cnt never exceeds FILT-1.

## Timing
- Reset (rst=1 at an edge): synchroniser flops 0, cnt 0, o = RST_VAL, chg 0, busy 0. Reset overrides en and any pending count. A count in progress is discarded and the filter restarts from 0 after reset releases.
- Latency: let edge k be the first edge at which a new `i`/`mode` value is presented. `o` updates at edge k + SYNC + FILT - 1, provided f stays constant throughout.
  - Example: SYNC=2, FILT=4 gives edge k+5.
  - Example: SYNC=0, FILT=1 gives edge k, i.e. `o` behaves as a plain registered gate.
- chg is high for exactly the cycle following the edge that updates `o`.
- `en` rising: counting starts on the first edge at which en=1 is sampled.
- Back-to-back changes: after an update, cnt=0. The next opposite transition needs a full FILT edges again.

## Test plan
- Reset and default state: N=2, mode=00, i=00, rst high for 2 cycles → o=1, chg=0, busy=0. Release reset and hold i for 10 cycles → o stays 1, no chg.
- Nominal NAND, SYNC=2, FILT=4: i goes 00→11, presented at edge k → o falls at edge k+5. chg is high for that one cycle. busy is high for 3 cycles beforehand.
- Glitch reject, SYNC=2, FILT=4: i goes 00→11 for 3 cycles, then back to 00 → o stays 1, chg is never asserted, busy returns to 0.
- Mode sweep, N=3, i=101, SYNC=0, FILT=1: mode steps 00,01,10,11, one mode per cycle → o = 1, 0, 0, 1, each valid on the edge at which that mode is presented.
- Enable and reset mid-count, FILT=8: mismatch held 5 cycles, then en=0 for 1 cycle → cnt=0, o unchanged; the update occurs 8 edges after en returns to 1. Repeat with rst pulsed at cycle 5 instead → o=RST_VAL, the count restarts from 0.
